// File: rtl/spi_sub_if.sv
// spi_sub_if: SPI wires between the AES link main and the spi_sub subordinate.
interface spi_sub_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_sub.sv
// spi_sub: SPI subordinate for the 128-bit AES block link, oversampled on clk.
// Optional feature: define SPI_SUB_LOOPBACK_EN to echo the last rx block when no tx block is pending.
module spi_sub #(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_sub_if.slave         spi,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_pending,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned SW = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE, DONE} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic [SW-1:0]          settle;
    logic                   settled;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_fall, cs_fall, cs_rise;
    logic                   start, abort, shift_en, last_bit, complete;
    logic [WIDTH-1:0]       holding, tx_shift, rx_shift, idle_fill;
    logic [CW-1:0]          bit_cnt;
    logic                   miso_d;

    // Settle counter: the cs_n chain resets to 1, so WAIT_HIGH must not trust it
    // until real samples have flushed the whole chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            settle    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (!settled)
                settle <= settle + SW'(1);
        end
    end

    assign settled   = (settle == SW'(SYNC_STAGES + 1));
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_s;
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;

    // cs_n edges take priority over a coincident sclk edge
    assign start    = (state == IDLE) && cs_fall;
    assign abort    = (state == ACTIVE) && cs_rise;
    assign shift_en = (state == ACTIVE) && !cs_rise && sclk_fall;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    assign complete = shift_en && last_bit;

`ifdef SPI_SUB_LOOPBACK_EN
    assign idle_fill = rx_data;
`else
    assign idle_fill = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WAIT_HIGH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_HIGH: if (settled && cs_s) state_next = IDLE;
            IDLE:      if (cs_fall)         state_next = ACTIVE;
            ACTIVE: begin
                if (cs_rise)
                    state_next = IDLE;
                else if (complete)
                    state_next = DONE;
            end
            DONE:      if (cs_rise)         state_next = IDLE;
            default:                        state_next = WAIT_HIGH;
        endcase
    end

    always_comb begin
        busy   = (state == ACTIVE);
        miso_d = (state == ACTIVE) ? tx_shift[WIDTH-1] : 1'b0;
    end

    assign spi.miso = miso_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holding    <= '0;
            tx_pending <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= complete;
            frame_err <= abort;
            if (start) begin
                tx_shift <= tx_pending ? holding : idle_fill;
                bit_cnt  <= '0;
            end else if (shift_en) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CW'(1);
            end
            if (complete)
                rx_data <= {rx_shift[WIDTH-2:0], mosi_s};
            // A load coinciding with frame start refills the holding register after
            // the frame has taken the old value, so pending stays set.
            if (tx_load) begin
                holding    <= tx_data;
                tx_pending <= 1'b1;
            end else if (start) begin
                tx_pending <= 1'b0;
            end
        end
    end
endmodule
